rr_mux4_stream: RTL and testbench

//  4:1 round-robin stream multiplexer: the gather side of the 1:4 demux path.
//  - Merges four valid/ready input channels into one registered output stream.
//  - Tags every output beat with its source channel on out_sel (2 bits). A

---
 rtl/rr_mux4_stream_if.sv | 37 +++
 rtl/rr_mux4_stream.sv | 142 ++++++++++++++
 tb/tb_rr_mux4_stream.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/rr_mux4_stream_if.sv
// Stream bundle for the 4:1 round-robin gather mux: four input channels plus one tagged output.
// Packet-end signals are present only when RR_PKT_LOCK_EN is defined.
interface rr_mux4_stream_if #(
  parameter int WIDTH = 8
);
  logic [4*WIDTH-1:0] in_data;
  logic [3:0]         in_valid;
  logic [3:0]         in_ready;
  logic [WIDTH-1:0]   out_data;
  logic [1:0]         out_sel;
  logic               out_valid;
  logic               out_ready;
`ifdef RR_PKT_LOCK_EN
  logic [3:0]         in_last;
  logic               out_last;

  modport master (
    output in_data, in_valid, in_last, out_ready,
    input  in_ready, out_data, out_sel, out_valid, out_last
  );

  modport slave (
    input  in_data, in_valid, in_last, out_ready,
    output in_ready, out_data, out_sel, out_valid, out_last
  );
`else
  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_sel, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_sel, out_valid
  );
`endif
endinterface

// File: rtl/rr_mux4_stream.sv
// 4:1 round-robin stream mux with a registered, source-tagged output beat.
// Define RR_PKT_LOCK_EN to hold the grant on one channel until its packet's last beat.
module rr_mux4_stream #(
  parameter int WIDTH = 8
) (
  input logic              clk,
  input logic              rst_n,
  rr_mux4_stream_if.slave  bus
);

  logic [1:0]       rr_ptr_r;
  logic [WIDTH-1:0] out_data_r;
  logic [1:0]       out_sel_r;
  logic             out_valid_r;

  logic             load_s;
  logic             any_s;
  logic             accept_s;
  logic [3:0]       req_s;
  logic [3:0]       rot_s;
  logic [1:0]       start_s;
  logic [1:0]       off_s;
  logic [1:0]       grant_s;
  logic [3:0]       ready_s;
  logic [WIDTH-1:0] sel_data_s;

`ifdef RR_PKT_LOCK_EN
  logic             lock_r;
  logic [1:0]       lock_ch_r;
  logic             out_last_r;
`endif

  assign load_s   = ~out_valid_r | bus.out_ready;
  assign any_s    = |req_s;
  assign accept_s = load_s & any_s;
  assign start_s  = rr_ptr_r + 2'd1;
  assign grant_s  = start_s + off_s;

  // Eligible requests: all valid channels, or only the locked one mid-packet
  always_comb begin
    req_s = bus.in_valid;
`ifdef RR_PKT_LOCK_EN
    if (lock_r) begin
      req_s = bus.in_valid & (4'b0001 << lock_ch_r);
    end else begin
      req_s = bus.in_valid;
    end
`endif
  end

  // Rotate requests so bit 0 is the channel just after the last grant
  always_comb begin
    rot_s = req_s;
    case (start_s)
      2'd0:    rot_s = req_s;
      2'd1:    rot_s = {req_s[0],   req_s[3:1]};
      2'd2:    rot_s = {req_s[1:0], req_s[3:2]};
      2'd3:    rot_s = {req_s[2:0], req_s[3]};
      default: rot_s = req_s;
    endcase
  end

  // Priority pick on the rotated vector gives the offset from start_s
  always_comb begin
    off_s = 2'd0;
    casez (rot_s)
      4'b???1: off_s = 2'd0;
      4'b??10: off_s = 2'd1;
      4'b?100: off_s = 2'd2;
      4'b1000: off_s = 2'd3;
      default: off_s = 2'd0;
    endcase
  end

  // One-hot ready to the granted channel, only when the output can load
  always_comb begin
    ready_s = 4'b0000;
    if (accept_s) begin
      ready_s = 4'b0001 << grant_s;
    end else begin
      ready_s = 4'b0000;
    end
  end

  // Data of the granted channel
  always_comb begin
    sel_data_s = bus.in_data[0 +: WIDTH];
    case (grant_s)
      2'd0:    sel_data_s = bus.in_data[0*WIDTH +: WIDTH];
      2'd1:    sel_data_s = bus.in_data[1*WIDTH +: WIDTH];
      2'd2:    sel_data_s = bus.in_data[2*WIDTH +: WIDTH];
      2'd3:    sel_data_s = bus.in_data[3*WIDTH +: WIDTH];
      default: sel_data_s = bus.in_data[0 +: WIDTH];
    endcase
  end

  // Output register and arbitration pointer; data/sel hold across drain and stall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      out_data_r  <= {WIDTH{1'b0}};
      out_sel_r   <= 2'd0;
      rr_ptr_r    <= 2'd3;
    end else if (accept_s) begin
      out_valid_r <= 1'b1;
      out_data_r  <= sel_data_s;
      out_sel_r   <= grant_s;
`ifdef RR_PKT_LOCK_EN
      if (bus.in_last[grant_s]) begin
        rr_ptr_r <= grant_s;
      end
`else
      rr_ptr_r    <= grant_s;
`endif
    end else if (load_s) begin
      out_valid_r <= 1'b0;
    end
  end

`ifdef RR_PKT_LOCK_EN
  // Packet lock tracking and registered last flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_r     <= 1'b0;
      lock_ch_r  <= 2'd0;
      out_last_r <= 1'b0;
    end else if (accept_s) begin
      out_last_r <= bus.in_last[grant_s];
      lock_r     <= ~bus.in_last[grant_s];
      lock_ch_r  <= grant_s;
    end
  end

  assign bus.out_last = out_last_r;
`endif

  assign bus.in_ready  = ready_s;
  assign bus.out_data  = out_data_r;
  assign bus.out_sel   = out_sel_r;
  assign bus.out_valid = out_valid_r;

endmodule

// File: tb/tb_rr_mux4_stream.sv
// Table-driven bench for rr_mux4_stream with a beat scoreboard; packet-lock
// sequence runs only when RR_PKT_LOCK_EN is defined.
module tb_rr_mux4_stream;
  localparam int W = 8;

  logic clk;
  logic rst_n;

  rr_mux4_stream_if #(.WIDTH(W)) bus();

  rr_mux4_stream #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [3:0]  vld;
    logic [31:0] data;
    logic [3:0]  last;
    logic        ordy;
    logic [3:0]  exp_rdy;
  } vec_t;

  typedef struct {
    logic [1:0] sel;
    logic [7:0] data;
    logic       last;
  } beat_t;

  vec_t  tbl[$];
  beat_t sb[$];

  int checks = 0;
  int errors = 0;

  logic       exp_valid;
  logic [7:0] exp_data;
  logic [1:0] exp_sel;
  logic       exp_last;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [3:0] vld, input logic [31:0] data,
                              input logic [3:0] last, input logic ordy,
                              input logic [3:0] rdy);
    vec_t v;
    v.vld = vld; v.data = data; v.last = last; v.ordy = ordy; v.exp_rdy = rdy;
    return v;
  endfunction

  function automatic int oh2idx(input logic [3:0] oh);
    for (int i = 0; i < 4; i++) if (oh[i]) return i;
    return 0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_out_valid"}, {31'd0, bus.out_valid}, {31'd0, exp_valid});
    chk({tag, "_out_data"}, {24'd0, bus.out_data}, {24'd0, exp_data});
    chk({tag, "_out_sel"}, {30'd0, bus.out_sel}, {30'd0, exp_sel});
`ifdef RR_PKT_LOCK_EN
    chk({tag, "_out_last"}, {31'd0, bus.out_last}, {31'd0, exp_last});
`endif
  endtask

  // Drive one cycle, check ready mid-cycle, then check the registered output
  task automatic apply(input vec_t v, input string tag);
    beat_t b;
    int k;
    bus.in_valid  = v.vld;
    bus.in_data   = v.data;
    bus.out_ready = v.ordy;
`ifdef RR_PKT_LOCK_EN
    bus.in_last   = v.last;
`endif
    #4;
    chk({tag, "_in_ready"}, {28'd0, bus.in_ready}, {28'd0, v.exp_rdy});
    if (v.exp_rdy != 4'b0000) begin
      k = oh2idx(v.exp_rdy);
      b.sel  = k[1:0];
      b.data = v.data[k*8 +: 8];
      b.last = v.last[k];
      sb.push_back(b);
    end
    @(posedge clk);
    #1;
    if (v.exp_rdy != 4'b0000) begin
      b = sb.pop_front();
      exp_valid = 1'b1;
      exp_data  = b.data;
      exp_sel   = b.sel;
      exp_last  = b.last;
    end else if (!exp_valid || v.ordy) begin
      exp_valid = 1'b0;
    end
    check_outputs(tag);
  endtask

  // Asynchronous reset with an immediate output check, released after an edge
  task automatic do_reset(input string tag);
    bus.in_valid  = 4'b0000;
    bus.in_data   = 32'd0;
    bus.out_ready = 1'b0;
`ifdef RR_PKT_LOCK_EN
    bus.in_last   = 4'b0000;
`endif
    rst_n = 1'b0;
    #1;
    exp_valid = 1'b0;
    exp_data  = 8'd0;
    exp_sel   = 2'd0;
    exp_last  = 1'b0;
    sb.delete();
    check_outputs({tag, "_rst"});
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b1;
    #2;
    do_reset("init");

    // T1: all channels valid, rotation 0,1,2,3,0
    tbl.push_back(mk(4'b1111, 32'hA3A2A1A0, 4'hF, 1'b1, 4'b0001));
    tbl.push_back(mk(4'b1111, 32'hA3A2A1A0, 4'hF, 1'b1, 4'b0010));
    tbl.push_back(mk(4'b1111, 32'hA3A2A1A0, 4'hF, 1'b1, 4'b0100));
    tbl.push_back(mk(4'b1111, 32'hA3A2A1A0, 4'hF, 1'b1, 4'b1000));
    tbl.push_back(mk(4'b1111, 32'hA3A2A1A0, 4'hF, 1'b1, 4'b0001));
    // T2: only ch2 valid
    tbl.push_back(mk(4'b0100, 32'h00550000, 4'hF, 1'b1, 4'b0100));
    tbl.push_back(mk(4'b0100, 32'h00550000, 4'hF, 1'b1, 4'b0100));
    tbl.push_back(mk(4'b0100, 32'h00550000, 4'hF, 1'b1, 4'b0100));
    // drain: out_valid drops, data/sel hold
    tbl.push_back(mk(4'b0000, 32'h00000000, 4'hF, 1'b1, 4'b0000));
    // T3: stall three cycles then resume at the next channel
    tbl.push_back(mk(4'b1111, 32'hB3B2B1B0, 4'hF, 1'b1, 4'b1000));
    tbl.push_back(mk(4'b1111, 32'hB3B2B1B0, 4'hF, 1'b0, 4'b0000));
    tbl.push_back(mk(4'b1111, 32'hB3B2B1B0, 4'hF, 1'b0, 4'b0000));
    tbl.push_back(mk(4'b1111, 32'hB3B2B1B0, 4'hF, 1'b0, 4'b0000));
    tbl.push_back(mk(4'b1111, 32'hB3B2B1B0, 4'hF, 1'b1, 4'b0001));
    // T4: ch1/ch3 with out_ready toggling
    tbl.push_back(mk(4'b1010, 32'hC3C2C1C0, 4'hF, 1'b1, 4'b0010));
    tbl.push_back(mk(4'b1010, 32'hC3C2C1C0, 4'hF, 1'b0, 4'b0000));
    tbl.push_back(mk(4'b1010, 32'hC3C2C1C0, 4'hF, 1'b1, 4'b1000));
    tbl.push_back(mk(4'b1010, 32'hC3C2C1C0, 4'hF, 1'b0, 4'b0000));
    tbl.push_back(mk(4'b1010, 32'hC3C2C1C0, 4'hF, 1'b1, 4'b0010));
    tbl.push_back(mk(4'b1010, 32'hC3C2C1C0, 4'hF, 1'b0, 4'b0000));
    tbl.push_back(mk(4'b1010, 32'hC3C2C1C0, 4'hF, 1'b1, 4'b1000));
    tbl.push_back(mk(4'b0000, 32'h00000000, 4'hF, 1'b1, 4'b0000));

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i], $sformatf("row%0d", i));
    end

    // T5: reset while a beat is held, then ch0 wins first
    apply(mk(4'b1111, 32'hD3D2D1D0, 4'hF, 1'b0, 4'b0001), "t5_fill");
    #2;
    do_reset("t5");
    apply(mk(4'b1111, 32'hE3E2E1E0, 4'hF, 1'b1, 4'b0001), "t5_first");

`ifdef RR_PKT_LOCK_EN
    // T6: ch0 three-beat packet holds the grant against ch1
    do_reset("t6");
    apply(mk(4'b0011, 32'h00001101, 4'b0000, 1'b1, 4'b0001), "t6_b1");
    apply(mk(4'b0011, 32'h00001102, 4'b0000, 1'b1, 4'b0001), "t6_b2");
    apply(mk(4'b0011, 32'h00001103, 4'b0001, 1'b1, 4'b0001), "t6_b3");
    apply(mk(4'b0010, 32'h00001100, 4'b0000, 1'b1, 4'b0010), "t6_ch1");
    apply(mk(4'b0000, 32'h00000000, 4'b0000, 1'b1, 4'b0000), "t6_drain");
`endif

    chk("sb_empty", sb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
